pito_mvu_sched: RTL and testbench



---
 rtl/pito_pkg.sv | 18 +
 rtl/pito_rr_arbiter.sv | 26 ++
 rtl/pito_mvu_sched.sv | 135 +++++++++++++
 tb/tb_pito_mvu_sched.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pito_pkg.sv
// Shared pito core definitions: hart count, hart id type and MVU scheduler
// state encoding.
package pito_pkg;

    localparam int PITO_NUM_HARTS      = 8;
    localparam int PITO_HART_ID_W      = $clog2(PITO_NUM_HARTS);
    localparam int MVU_SCHED_TIMEOUT_W = 16;

    typedef logic [PITO_HART_ID_W-1:0] pito_hart_id_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        DONE
    } mvu_sched_state_e;

endpackage

// File: rtl/pito_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found after
// 'last', searching upward with wrap-around.
module pito_rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int IW = $clog2(N);

    // Offsets 1..N from last; the final offset wraps back to last itself.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int k = 1; k <= N; k++) begin
            if (!gnt_valid && req[IW'((int'(last) + k) % N)]) begin
                gnt_valid = 1'b1;
                gnt_id    = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/pito_mvu_sched.sv
// Shares one MVU command port among the pito harts: latches per-hart requests,
// grants round-robin, runs a per-job watchdog and returns irq/err to the owner.
module pito_mvu_sched
    import pito_pkg::*;
#(
    parameter int NUM_HARTS = PITO_NUM_HARTS,
    parameter int CMD_W     = 32,
    parameter int TIMEOUT_W = MVU_SCHED_TIMEOUT_W
) (
    input  logic                         clk,
    input  logic                         pito_io_rst_n,
    input  logic [NUM_HARTS-1:0]         mvu_start_i,
    input  logic [CMD_W*NUM_HARTS-1:0]   csr_mvucommand_i,
    input  logic [TIMEOUT_W-1:0]         timeout_cycles_i,
    input  logic                         mvu_done_i,
    output logic                         mvu_start_o,
    output logic [CMD_W-1:0]             mvu_cmd_o,
    output logic [$clog2(NUM_HARTS)-1:0] mvu_hart_o,
    output logic [NUM_HARTS-1:0]         mvu_irq_o,
    output logic [NUM_HARTS-1:0]         mvu_err_o,
    output logic [NUM_HARTS-1:0]         mvu_busy_o
);

    localparam int HW = $clog2(NUM_HARTS);

    mvu_sched_state_e     state_q, state_d;
    logic [HW-1:0]        owner_q;
    logic [HW-1:0]        last_grant_q;
    logic [NUM_HARTS-1:0] pending_q;
    logic [CMD_W-1:0]     cmd_q [NUM_HARTS];
    logic [TIMEOUT_W-1:0] timer_q;
    logic                 timed_out_q;

    logic                 gnt_valid;
    logic [HW-1:0]        gnt_id;
    logic [NUM_HARTS-1:0] owner_oh;
    logic [NUM_HARTS-1:0] owner_active;
    logic [NUM_HARTS-1:0] launch_clr;
    logic [NUM_HARTS-1:0] accept;

    // A hart cannot queue a second job while its own job is launching or running.
    assign owner_oh     = NUM_HARTS'(1) << owner_q;
    assign owner_active = (state_q == LAUNCH || state_q == RUN) ? owner_oh : '0;
    assign launch_clr   = (state_q == LAUNCH) ? owner_oh : '0;
    assign accept       = mvu_start_i & ~pending_q & ~owner_active;

    assign mvu_hart_o   = owner_q;
    assign mvu_busy_o   = pending_q | ((state_q != IDLE) ? owner_oh : '0);

    pito_rr_arbiter #(
        .N(NUM_HARTS)
    ) u_arb (
        .req       (pending_q),
        .last      (last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or negedge pito_io_rst_n) begin
        if (!pito_io_rst_n) begin
            pending_q <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                cmd_q[h] <= '0;
            end
        end else begin
            pending_q <= (pending_q | accept) & ~launch_clr;
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (accept[h]) begin
                    cmd_q[h] <= csr_mvucommand_i[CMD_W*h +: CMD_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge pito_io_rst_n) begin
        if (!pito_io_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero timer means the watchdog is disabled for this job.
    always_comb begin
        state_d     = state_q;
        mvu_start_o = 1'b0;
        mvu_irq_o   = '0;
        mvu_err_o   = '0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) state_d = LAUNCH;
            end
            LAUNCH: begin
                mvu_start_o = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (mvu_done_i || timer_q == TIMEOUT_W'(1)) state_d = DONE;
            end
            DONE: begin
                if (timed_out_q) mvu_err_o = owner_oh;
                else             mvu_irq_o = owner_oh;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge pito_io_rst_n) begin
        if (!pito_io_rst_n) begin
            owner_q      <= '0;
            last_grant_q <= HW'(NUM_HARTS - 1);
            mvu_cmd_o    <= '0;
            timer_q      <= '0;
            timed_out_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        owner_q   <= gnt_id;
                        mvu_cmd_o <= cmd_q[gnt_id];
                    end
                end
                LAUNCH: timer_q <= timeout_cycles_i;
                RUN: begin
                    timed_out_q <= ~mvu_done_i;
                    if (timer_q != '0) timer_q <= timer_q - TIMEOUT_W'(1);
                end
                DONE: last_grant_q <= owner_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pito_mvu_sched.sv
// Bench for pito_mvu_sched: directed job table, hand-written arbitration and
// reset sequences, then random traffic against a cycle-time reference model.
module tb_pito_mvu_sched;
    import pito_pkg::*;

    localparam int NH = 8;
    localparam int CW = 32;
    localparam int TW = 16;

    logic              clk = 1'b0;
    logic              pito_io_rst_n;
    logic [NH-1:0]     mvu_start_i;
    logic [CW*NH-1:0]  csr_mvucommand_i;
    logic [TW-1:0]     timeout_cycles_i;
    logic              mvu_done_i;
    logic              mvu_start_o;
    logic [CW-1:0]     mvu_cmd_o;
    pito_hart_id_t     mvu_hart_o;
    logic [NH-1:0]     mvu_irq_o;
    logic [NH-1:0]     mvu_err_o;
    logic [NH-1:0]     mvu_busy_o;

    int checks = 0;
    int errors = 0;

    pito_mvu_sched #(
        .NUM_HARTS (NH),
        .CMD_W     (CW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk              (clk),
        .pito_io_rst_n    (pito_io_rst_n),
        .mvu_start_i      (mvu_start_i),
        .csr_mvucommand_i (csr_mvucommand_i),
        .timeout_cycles_i (timeout_cycles_i),
        .mvu_done_i       (mvu_done_i),
        .mvu_start_o      (mvu_start_o),
        .mvu_cmd_o        (mvu_cmd_o),
        .mvu_hart_o       (mvu_hart_o),
        .mvu_irq_o        (mvu_irq_o),
        .mvu_err_o        (mvu_err_o),
        .mvu_busy_o       (mvu_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          hart;
        logic [31:0] cmd;
        logic [15:0] tmo;
        int          done_dly;
        logic [7:0]  exp_irq;
        logic [7:0]  exp_err;
        int          exp_after;
    } job_vec_t;

    job_vec_t vecs[7];

    // Reference model: job timeline kept as absolute cycle numbers.
    logic [NH-1:0] m_pend;
    logic [CW-1:0] m_cmdq [NH];
    bit            m_job;
    int            m_own;
    int            m_launch;
    int            m_finish;
    bit            m_err;
    int            m_tmo;
    int            m_last;
    int            m_cyc;
    logic [CW-1:0] m_cmd_out;
    int            m_hart_out;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NH-1:0] mask);
        mvu_start_i = mask;
    endtask

    task automatic set_cmd(input int h, input logic [CW-1:0] c);
        csr_mvucommand_i[CW*h +: CW] = c;
    endtask

    task automatic request(input logic [NH-1:0] mask);
        applyStimulus(mask);
        step();
        mvu_start_i = '0;
    endtask

    task automatic wait_launch(output int n);
        n = 0;
        while (!mvu_start_o && n < 64) begin
            step();
            n++;
        end
        checkOutput("launch seen", 64'(mvu_start_o), 64'd1);
    endtask

    // Called in the launch cycle; returns in the following IDLE cycle.
    task automatic complete_job();
        step();
        mvu_done_i = 1'b1;
        step();
        mvu_done_i = 1'b0;
        step();
    endtask

    task automatic do_reset();
        pito_io_rst_n = 1'b0;
        mvu_start_i   = '0;
        mvu_done_i    = 1'b0;
        step();
        step();
        pito_io_rst_n = 1'b1;
    endtask

    task automatic check_quiet(input string name);
        checkOutput({name, " start"}, 64'(mvu_start_o), 64'd0);
        checkOutput({name, " irq"},   64'(mvu_irq_o),   64'd0);
        checkOutput({name, " err"},   64'(mvu_err_o),   64'd0);
        checkOutput({name, " busy"},  64'(mvu_busy_o),  64'd0);
    endtask

    task automatic model_reset();
        m_pend = '0;
        for (int h = 0; h < NH; h++) m_cmdq[h] = '0;
        m_job      = 1'b0;
        m_own      = 0;
        m_launch   = -1;
        m_finish   = -1;
        m_err      = 1'b0;
        m_tmo      = 0;
        m_last     = NH - 1;
        m_cyc      = 0;
        m_cmd_out  = '0;
        m_hart_out = 0;
    endtask

    task automatic model_check();
        logic [NH-1:0] e_irq;
        logic [NH-1:0] e_err;
        logic [NH-1:0] e_busy;
        e_irq  = '0;
        e_err  = '0;
        e_busy = m_pend;
        if (m_job) e_busy[m_own] = 1'b1;
        if (m_job && m_cyc == m_finish) begin
            if (m_err) e_err[m_own] = 1'b1;
            else       e_irq[m_own] = 1'b1;
        end
        checkOutput("rand start", 64'(mvu_start_o), 64'(m_job && m_cyc == m_launch));
        checkOutput("rand cmd",   64'(mvu_cmd_o),   64'(m_cmd_out));
        checkOutput("rand hart",  64'(mvu_hart_o),  64'(m_hart_out));
        checkOutput("rand irq",   64'(mvu_irq_o),   64'(e_irq));
        checkOutput("rand err",   64'(mvu_err_o),   64'(e_err));
        checkOutput("rand busy",  64'(mvu_busy_o),  64'(e_busy));
    endtask

    task automatic model_advance();
        logic [NH-1:0] acc;
        bit            found;
        for (int h = 0; h < NH; h++) begin
            acc[h] = mvu_start_i[h] && !m_pend[h] &&
                     !(m_job && m_own == h && m_cyc != m_finish);
        end
        if (m_job) begin
            if (m_cyc == m_launch) begin
                m_pend[m_own] = 1'b0;
                m_tmo = int'(timeout_cycles_i);
            end else if (m_cyc == m_finish) begin
                m_job  = 1'b0;
                m_last = m_own;
            end else if (m_finish < 0) begin
                if (mvu_done_i) begin
                    m_finish = m_cyc + 1;
                    m_err    = 1'b0;
                end else if (m_tmo != 0 && m_cyc == m_launch + m_tmo) begin
                    m_finish = m_cyc + 1;
                    m_err    = 1'b1;
                end
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NH; k++) begin
                int h;
                h = (m_last + k) % NH;
                if (!found && m_pend[h]) begin
                    found      = 1'b1;
                    m_job      = 1'b1;
                    m_own      = h;
                    m_launch   = m_cyc + 1;
                    m_finish   = -1;
                    m_cmd_out  = m_cmdq[h];
                    m_hart_out = h;
                end
            end
        end
        for (int h = 0; h < NH; h++) begin
            if (acc[h]) begin
                m_pend[h] = 1'b1;
                m_cmdq[h] = csr_mvucommand_i[CW*h +: CW];
            end
        end
        m_cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            n;
        int            cnt;
        bit            got;
        logic [NH-1:0] mask;
        int            n_launch;
        int            n_irq;
        int            n_err;
        int            launch_cyc;
        int            cyc;

        vecs[0] = '{3, 32'h0000_00A5, 16'd0,  10, 8'h08, 8'h00, 11};
        vecs[1] = '{5, 32'h5555_0005, 16'd20, 0,  8'h00, 8'h20, 21};
        vecs[2] = '{6, 32'hDEAD_BEEF, 16'd20, 20, 8'h40, 8'h00, 21};
        vecs[3] = '{0, 32'h0000_0100, 16'd20, 19, 8'h01, 8'h00, 20};
        vecs[4] = '{7, 32'h7777_7777, 16'd1,  0,  8'h00, 8'h80, 2};
        vecs[5] = '{4, 32'h4444_0044, 16'd0,  1,  8'h10, 8'h00, 2};
        vecs[6] = '{1, 32'h1111_0003, 16'd3,  0,  8'h00, 8'h02, 4};

        pito_io_rst_n    = 1'b0;
        mvu_start_i      = '0;
        csr_mvucommand_i = '0;
        timeout_cycles_i = '0;
        mvu_done_i       = 1'b0;

        step();
        check_quiet("reset");
        checkOutput("reset cmd",  64'(mvu_cmd_o),  64'd0);
        checkOutput("reset hart", 64'(mvu_hart_o), 64'd0);
        step();
        pito_io_rst_n = 1'b1;
        step();

        $display("[TB] directed job table");
        for (int i = 0; i < 7; i++) begin
            mask = NH'(1) << vecs[i].hart;
            timeout_cycles_i = vecs[i].tmo;
            set_cmd(vecs[i].hart, vecs[i].cmd);
            request(mask);
            checkOutput("busy after request", 64'(mvu_busy_o), 64'(mask));
            wait_launch(n);
            checkOutput("launch latency", 64'(n + 1), 64'd2);
            checkOutput("launch cmd",     64'(mvu_cmd_o), 64'(vecs[i].cmd));
            checkOutput("launch hart",    64'(mvu_hart_o), 64'(vecs[i].hart));
            cnt = 0;
            got = 1'b0;
            while (!got && cnt < 100) begin
                mvu_done_i = (vecs[i].done_dly != 0 && cnt == vecs[i].done_dly);
                step();
                cnt++;
                if (cnt == 1) timeout_cycles_i = 16'd2;
                got = (mvu_irq_o != '0 || mvu_err_o != '0);
            end
            mvu_done_i = 1'b1;
            checkOutput("job irq",      64'(mvu_irq_o), 64'(vecs[i].exp_irq));
            checkOutput("job err",      64'(mvu_err_o), 64'(vecs[i].exp_err));
            checkOutput("job duration", 64'(cnt),       64'(vecs[i].exp_after));
            checkOutput("cmd held",     64'(mvu_cmd_o), 64'(vecs[i].cmd));
            step();
            check_quiet("after done");
            step();
            mvu_done_i = 1'b0;
            check_quiet("late done");
        end

        $display("[TB] all harts request together");
        timeout_cycles_i = '0;
        do_reset();
        for (int h = 0; h < NH; h++) set_cmd(h, 32'hC000_0000 | h);
        request('1);
        n_launch   = 0;
        n_irq      = 0;
        n_err      = 0;
        launch_cyc = -100;
        cyc        = 1;
        while (n_irq < NH && cyc < 400) begin
            if (mvu_start_o) begin
                checkOutput("rr order", 64'(mvu_hart_o), 64'(n_launch));
                checkOutput("rr cmd",   64'(mvu_cmd_o),  64'(32'hC000_0000 | n_launch));
                launch_cyc = cyc;
                n_launch++;
            end
            n_irq += $countones(mvu_irq_o);
            n_err += $countones(mvu_err_o);
            mvu_done_i = (cyc == launch_cyc + 5);
            step();
            cyc++;
        end
        mvu_done_i = 1'b0;
        checkOutput("all-harts launches", 64'(n_launch), 64'd8);
        checkOutput("all-harts irqs",     64'(n_irq),    64'd8);
        checkOutput("all-harts errs",     64'(n_err),    64'd0);
        step();
        step();

        $display("[TB] rotation after hart 2");
        set_cmd(2, 32'h0000_0222);
        request(8'h04);
        wait_launch(n);
        checkOutput("rot first hart", 64'(mvu_hart_o), 64'd2);
        step();
        set_cmd(1, 32'h0000_0111);
        set_cmd(4, 32'h0000_0444);
        applyStimulus(8'h12);
        step();
        mvu_start_i = '0;
        mvu_done_i  = 1'b1;
        step();
        mvu_done_i  = 1'b0;
        checkOutput("rot irq hart 2", 64'(mvu_irq_o), 64'h04);
        wait_launch(n);
        checkOutput("rot second hart", 64'(mvu_hart_o), 64'd4);
        checkOutput("rot second cmd",  64'(mvu_cmd_o),  64'h0444);
        complete_job();
        wait_launch(n);
        checkOutput("rot third hart", 64'(mvu_hart_o), 64'd1);
        complete_job();

        $display("[TB] re-request by owner");
        set_cmd(1, 32'h0000_1A1A);
        request(8'h02);
        wait_launch(n);
        checkOutput("owner first hart", 64'(mvu_hart_o), 64'd1);
        step();
        set_cmd(1, 32'hBAD0_0001);
        applyStimulus(8'h02);
        step();
        mvu_start_i = '0;
        checkOutput("owner cmd stable", 64'(mvu_cmd_o),  64'h1A1A);
        checkOutput("owner busy run",   64'(mvu_busy_o), 64'h02);
        mvu_done_i = 1'b1;
        step();
        mvu_done_i = 1'b0;
        checkOutput("owner irq", 64'(mvu_irq_o), 64'h02);
        set_cmd(1, 32'h0000_2B2B);
        request(8'h02);
        checkOutput("owner busy pending", 64'(mvu_busy_o), 64'h02);
        wait_launch(n);
        checkOutput("owner relaunch latency", 64'(n), 64'd1);
        checkOutput("owner relaunch cmd",     64'(mvu_cmd_o), 64'h2B2B);
        complete_job();
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (mvu_start_o) cnt++;
            step();
        end
        checkOutput("owner no extra launch", 64'(cnt), 64'd0);
        checkOutput("owner busy clear",      64'(mvu_busy_o), 64'd0);

        $display("[TB] reset during run");
        set_cmd(6, 32'h6666_6666);
        request(8'h40);
        wait_launch(n);
        step();
        step();
        #2;
        pito_io_rst_n = 1'b0;
        #1;
        check_quiet("async reset");
        checkOutput("async reset cmd",  64'(mvu_cmd_o),  64'd0);
        checkOutput("async reset hart", 64'(mvu_hart_o), 64'd0);
        step();
        step();
        pito_io_rst_n = 1'b1;
        mvu_done_i    = 1'b1;
        step();
        mvu_done_i    = 1'b0;
        check_quiet("post-reset done");
        step();
        check_quiet("post-reset idle");

        $display("[TB] random traffic");
        do_reset();
        model_reset();
        for (int c = 0; c < 2500; c++) begin
            model_check();
            for (int h = 0; h < NH; h++) begin
                mvu_start_i[h] = ($urandom_range(0, 11) == 0);
                csr_mvucommand_i[CW*h +: CW] = $urandom();
            end
            mvu_done_i       = ($urandom_range(0, 5) == 0);
            timeout_cycles_i = TW'($urandom_range(0, 12));
            model_advance();
            step();
        end
        mvu_start_i = '0;
        mvu_done_i  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
